extra_slot_arbiter: RTL and testbench
=====================================

// Module: extra_slot_arbiter
// PURPOSE
// - Owns the third bus cycle (busCycle==2'b10) of the 4-clock memory interleave, the "extra slot".
// - Grants it on demand to internal floppy, external floppy, sound and SCSI DMA, instead of a fixed 4-slot rotation.
// - Sound has a bounded-latency guarantee.
// - Drives the extra-slot address and the ROM/RAM read and RAM write strobes into the RAM/ROM address mux.
// PARAMETERS
// - ADDR_W        22         memory address width
// - DSK_INT_BASE  22'h020000 offset added to the internal floppy image address (ROM side)
// - DSK_EXT_BASE  22'h120000 offset added to the external floppy image address (ROM side)
// - SCSI_BASE     22'h200000 offset added to the SCSI DMA address (RAM side)
// - SND_MAX_WAIT  2          max consecutive extra slots sound may be denied while requesting; 1..7
// PORTS
// - clk8          in  1      8.125 MHz system clock; all state on posedge
// - _reset        in  1      asynchronous, active-low reset
// - busCycle      in  2      interleave phase from the address controller
// - reqDskInt     in  1      internal floppy read request; level, held until ackDskInt
// - reqDskExt     in  1      external floppy read request; level, held until ackDskExt
// - reqSnd        in  1      sound sample read request; level, held until ackSnd
// - reqScsi       in  1      SCSI DMA request; level, held until ackScsi
// - scsiWrite     in  1      1 = SCSI DMA write to RAM, 0 = read; sampled with reqScsi
// - addrDskInt    in  ADDR_W internal floppy image byte address
// - addrDskExt    in  ADDR_W external floppy image byte address
// - addrSnd       in  ADDR_W absolute sound buffer address
// - addrScsi      in  ADDR_W SCSI DMA buffer address
// - ackDskInt     out 1      high for exactly the granted extra-slot cycle
// - ackDskExt     out 1      same, for the external floppy
// - ackSnd        out 1      same, for sound
// - ackScsi       out 1      same, for SCSI DMA
// - extraAddr     out ADDR_W address for the extra slot (base + requester address); 0 when idle
// - extraRomRead  out 1      ROM OE request (floppy grants)
// - extraRamRead  out 1      RAM OE request (sound, SCSI read)
// - extraRamWrite out 1      RAM WE request (SCSI write)
// BEHAVIOUR
// - Reset (async, _reset=0): grant register=none, rrPtr=0, sndWait=0.
//   - All ack/strobe outputs are 0 and extraAddr is 0 while _reset is low and on release.
// - Decision point: posedge clk8 with busCycle==2'b01.
//   - Samples all req*, registers a one-hot grant (or none), latches scsiWrite.
// - Grant is valid only while busCycle==2'b10; outputs are decoded combinationally from grant & (busCycle==2'b10).
//   - Latency: req seen at a decision edge -> ack during the next clock (1-2 clk8 from a req edge aligned to busCycle 01).
// - Grant register clears on the posedge with busCycle==2'b10; each grant yields exactly one 1-cycle ack.
// - Priority, evaluated at the decision point:
//   1. reqSnd && sndWait>=SND_MAX_WAIT -> sound (urgent override).
//   2. Otherwise round-robin over {DskInt=0, DskExt=1, Snd=2, Scsi=3}, starting at rrPtr.
//   3. No requests -> none. rrPtr is unchanged and the slot is idle.
// - rrPtr update: on any grant, rrPtr <= granted index + 1 (mod 4), including urgent sound grants.
// - sndWait update, at each decision point:
//   - reset to 0 if sound is granted or reqSnd==0;
//   - otherwise incremented, saturating at 7.
// - extraAddr sums truncate to ADDR_W; wrap is silent; requesters must keep images inside memory.
// - Requester dropping req after the decision still receives the ack; it must ignore it (protocol violation, not checked).
// - busCycle not advancing (held) gives no new decisions; an outstanding grant stays until busCycle==2'b10.
// - Mid-slot reset aborts the grant immediately; no ack pulse survives reset assertion.
// - Strobes are mutually exclusive by construction; the floppy grant raises only extraRomRead.
// STRUCTURE
// - Shared include extra_slot_defs.vh holds:
//   - slot indices (SLOT_DSK_INT..SLOT_SCSI);
//   - busCycle phase constants (BC_VIDEO=0, BC_CPU=1, BC_EXTRA=2, BC_TURBO=3);
//   - default base offsets.
// - Sub-module rr_pick4: combinational 4-way round-robin picker (req[3:0], ptr[1:0] -> onehot gnt[3:0]).
// - Top keeps the grant register, rrPtr, sndWait and the output decode.
// TESTING
// - Reset: hold _reset=0 with all reqs high for 8 clocks -> all acks/strobes 0, extraAddr 0.
//   - Release -> first ack is ackDskInt at the first busCycle==2'b10.
// - Single requester: reqDskExt=1, addrDskExt=22'h001234 -> ackDskExt with extraAddr=22'h121234 and extraRomRead=1, once per 4 clocks.
// - All four requesting continuously -> grants cycle DskInt, DskExt, Snd, Scsi.
//   - Each ack is 1 cycle wide and every 4th clock; no slot is idle.
// - Urgent sound: SND_MAX_WAIT=2; reqDskInt, reqDskExt and reqScsi always high; reqSnd is raised just after its round-robin turn.
//   - Sound is granted at no later than the 3rd decision point after reqSnd rises.
// - SCSI write: reqScsi=1, scsiWrite=1, addrScsi=22'h000100 -> extraRamWrite=1, extraAddr=22'h200100, both read strobes 0.
// - Reset asserted during busCycle==2'b10 with an active grant -> ack drops the same instant; after release, rrPtr=0 and sndWait=0.

Source files
------------

// File: rtl/extra_slot_arbiter_pkg.sv
// Shared constants for the extra-slot arbiter: requester slot indices, interleave
// phases, default image/buffer base offsets and a one-hot to index helper.
package extra_slot_arbiter_pkg;

  localparam int SLOT_DSK_INT = 0;
  localparam int SLOT_DSK_EXT = 1;
  localparam int SLOT_SND     = 2;
  localparam int SLOT_SCSI    = 3;

  localparam logic [1:0] BC_VIDEO = 2'd0;
  localparam logic [1:0] BC_CPU   = 2'd1;
  localparam logic [1:0] BC_EXTRA = 2'd2;
  localparam logic [1:0] BC_TURBO = 2'd3;

  localparam logic [21:0] DEF_DSK_INT_BASE = 22'h020000;
  localparam logic [21:0] DEF_DSK_EXT_BASE = 22'h120000;
  localparam logic [21:0] DEF_SCSI_BASE    = 22'h200000;

  localparam logic [2:0] SND_WAIT_SAT = 3'd7;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/extra_slot_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: the first requester at or after ptr_i
// (wrapping) wins; no request gives an all-zero grant.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/extra_slot_arbiter.sv
// Arbiter for the third bus cycle of the 4-clock interleave: grants the extra slot
// on demand to the floppies, sound and SCSI DMA, with a bounded wait for sound.
module extra_slot_arbiter
  import extra_slot_arbiter_pkg::*;
#(
  parameter int                 ADDR_W       = 22,
  parameter logic [ADDR_W-1:0]  DSK_INT_BASE = ADDR_W'(DEF_DSK_INT_BASE),
  parameter logic [ADDR_W-1:0]  DSK_EXT_BASE = ADDR_W'(DEF_DSK_EXT_BASE),
  parameter logic [ADDR_W-1:0]  SCSI_BASE    = ADDR_W'(DEF_SCSI_BASE),
  parameter int                 SND_MAX_WAIT = 2
) (
  input  logic              clk8,
  input  logic              _reset,
  input  logic [1:0]        busCycle,
  input  logic              reqDskInt,
  input  logic              reqDskExt,
  input  logic              reqSnd,
  input  logic              reqScsi,
  input  logic              scsiWrite,
  input  logic [ADDR_W-1:0] addrDskInt,
  input  logic [ADDR_W-1:0] addrDskExt,
  input  logic [ADDR_W-1:0] addrSnd,
  input  logic [ADDR_W-1:0] addrScsi,
  output logic              ackDskInt,
  output logic              ackDskExt,
  output logic              ackSnd,
  output logic              ackScsi,
  output logic [ADDR_W-1:0] extraAddr,
  output logic              extraRomRead,
  output logic              extraRamRead,
  output logic              extraRamWrite
);

  // Handshake: each req* is a level held until its ack*; requests are sampled on the
  // posedge with busCycle==BC_CPU and the winner's ack is high for exactly the
  // following BC_EXTRA cycle. An ack arriving after a dropped req is ignored upstream.

  localparam logic [2:0] SND_MAX_W = 3'(SND_MAX_WAIT);

  logic [3:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] snd_wait_q, snd_wait_d;
  logic       scsi_wr_q, scsi_wr_d;

  logic [3:0] req_vec, rr_gnt, pick, slot_gnt;
  logic       decide, in_slot, urgent;

  assign req_vec = {reqScsi, reqSnd, reqDskExt, reqDskInt};
  assign decide  = (busCycle == BC_CPU);
  assign in_slot = (busCycle == BC_EXTRA);
  assign urgent  = reqSnd && (snd_wait_q >= SND_MAX_W);

  rr_pick4 u_pick (
    .req_i (req_vec),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  assign pick = urgent ? 4'b0100 : rr_gnt;

  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    snd_wait_d = snd_wait_q;
    scsi_wr_d  = scsi_wr_q;
    if (decide) begin
      grant_d   = pick;
      scsi_wr_d = scsiWrite;
      if (|pick) rr_ptr_d = onehot_to_idx(pick) + 2'd1;
      if (pick[SLOT_SND] || !reqSnd) snd_wait_d = '0;
      else if (snd_wait_q != SND_WAIT_SAT) snd_wait_d = snd_wait_q + 3'd1;
    end else if (in_slot) begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      snd_wait_q <= '0;
      scsi_wr_q  <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      snd_wait_q <= snd_wait_d;
      scsi_wr_q  <= scsi_wr_d;
    end
  end

  // Outputs are pure decode of the held grant, so reset kills an active ack at once.
  assign slot_gnt = grant_q & {4{in_slot}};

  assign ackDskInt     = slot_gnt[SLOT_DSK_INT];
  assign ackDskExt     = slot_gnt[SLOT_DSK_EXT];
  assign ackSnd        = slot_gnt[SLOT_SND];
  assign ackScsi       = slot_gnt[SLOT_SCSI];
  assign extraRomRead  = slot_gnt[SLOT_DSK_INT] | slot_gnt[SLOT_DSK_EXT];
  assign extraRamRead  = slot_gnt[SLOT_SND] | (slot_gnt[SLOT_SCSI] & ~scsi_wr_q);
  assign extraRamWrite = slot_gnt[SLOT_SCSI] & scsi_wr_q;

  always_comb begin
    extraAddr = '0;
    if (slot_gnt[SLOT_DSK_INT])      extraAddr = DSK_INT_BASE + addrDskInt;
    else if (slot_gnt[SLOT_DSK_EXT]) extraAddr = DSK_EXT_BASE + addrDskExt;
    else if (slot_gnt[SLOT_SND])     extraAddr = addrSnd;
    else if (slot_gnt[SLOT_SCSI])    extraAddr = SCSI_BASE + addrScsi;
  end

endmodule

// File: tb/tb_extra_slot_arbiter.sv
// Bench for extra_slot_arbiter: directed phases plus random requests, checked by a
// decision-level reference model feeding an expected queue drained by a slot monitor.
module tb_extra_slot_arbiter;

  localparam int ADDR_W       = 22;
  localparam int SND_MAX_WAIT = 2;
  localparam int EXP_W        = 4 + ADDR_W + 3;
  localparam logic [ADDR_W-1:0] B_INT  = 22'h020000;
  localparam logic [ADDR_W-1:0] B_EXT  = 22'h120000;
  localparam logic [ADDR_W-1:0] B_SCSI = 22'h200000;

  logic              clk8;
  logic              _reset;
  logic [1:0]        busCycle;
  logic              reqDskInt, reqDskExt, reqSnd, reqScsi, scsiWrite;
  logic [ADDR_W-1:0] addrDskInt, addrDskExt, addrSnd, addrScsi;
  logic              ackDskInt, ackDskExt, ackSnd, ackScsi;
  logic [ADDR_W-1:0] extraAddr;
  logic              extraRomRead, extraRamRead, extraRamWrite;

  extra_slot_arbiter #(.ADDR_W(ADDR_W), .SND_MAX_WAIT(SND_MAX_WAIT)) dut (
    .clk8          (clk8),
    ._reset        (_reset),
    .busCycle      (busCycle),
    .reqDskInt     (reqDskInt),
    .reqDskExt     (reqDskExt),
    .reqSnd        (reqSnd),
    .reqScsi       (reqScsi),
    .scsiWrite     (scsiWrite),
    .addrDskInt    (addrDskInt),
    .addrDskExt    (addrDskExt),
    .addrSnd       (addrSnd),
    .addrScsi      (addrScsi),
    .ackDskInt     (ackDskInt),
    .ackDskExt     (ackDskExt),
    .ackSnd        (ackSnd),
    .ackScsi       (ackScsi),
    .extraAddr     (extraAddr),
    .extraRomRead  (extraRomRead),
    .extraRamRead  (extraRamRead),
    .extraRamWrite (extraRamWrite)
  );

  // ---------------- clock / reset / interleave phase ----------------
  initial begin
    clk8 = 1'b0;
    forever #5 clk8 = ~clk8;
  end

  initial begin
    busCycle = 2'd0;
    forever begin
      @(posedge clk8);
      #1 busCycle = busCycle + 2'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];
  int m_ptr    = 0;
  int m_wait   = 0;
  int m_last_g = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one arbitration per decision point, straight from the rules.
  task automatic model_decide();
    logic [3:0]        r;
    logic [3:0]        a;
    logic [ADDR_W-1:0] ad;
    logic              rom, rrd, rwr;
    int                g;
    r   = {reqScsi, reqSnd, reqDskExt, reqDskInt};
    g   = -1;
    a   = '0;
    ad  = '0;
    rom = 1'b0;
    rrd = 1'b0;
    rwr = 1'b0;
    if (r[2] && m_wait >= SND_MAX_WAIT) g = 2;
    else for (int k = 0; k < 4; k++) if (g < 0 && r[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    if (g >= 0) m_ptr = (g + 1) % 4;
    if (g == 2 || !r[2]) m_wait = 0;
    else if (m_wait < 7) m_wait++;
    case (g)
      0: begin a[0] = 1'b1; ad = B_INT + addrDskInt; rom = 1'b1; end
      1: begin a[1] = 1'b1; ad = B_EXT + addrDskExt; rom = 1'b1; end
      2: begin a[2] = 1'b1; ad = addrSnd; rrd = 1'b1; end
      3: begin a[3] = 1'b1; ad = B_SCSI + addrScsi; rwr = scsiWrite; rrd = !scsiWrite; end
      default: ;
    endcase
    exp_q.push_back({a, ad, rom, rrd, rwr});
    m_last_g = g;
  endtask

  always @(posedge clk8) begin
    if (_reset === 1'b1 && busCycle == 2'b01) model_decide();
  end

  // Monitor: every cycle is checked; the extra slot pops one expectation.
  always @(negedge clk8) begin
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] exp;
    act = {ackScsi, ackSnd, ackDskExt, ackDskInt, extraAddr,
           extraRomRead, extraRamRead, extraRamWrite};
    if (_reset !== 1'b1) begin
      check("reset_quiet", 32'(act), 32'd0);
    end else if (busCycle == 2'b10) begin
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = '0;
      check("slot", 32'(act), 32'(exp));
    end else begin
      check("idle_phase", 32'(act), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_slot();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk8);
      if (busCycle == 2'b10) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL slot_timeout: no extra slot seen, required one within 16 clocks");
    end
  endtask

  task automatic step_post_slot();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(posedge clk8);
      #2;
      if (busCycle == 2'b11) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL phase_timeout: busCycle 3 not seen, required within 16 clocks");
    end
  endtask

  task automatic set_reqs(input logic [3:0] r);
    {reqScsi, reqSnd, reqDskExt, reqDskInt} = r;
  endtask

  function automatic logic [3:0] acks();
    return {ackScsi, ackSnd, ackDskExt, ackDskInt};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    _reset     = 1'b0;
    scsiWrite  = 1'b0;
    addrDskInt = 22'h000040;
    addrDskExt = 22'h000080;
    addrSnd    = 22'h3fa000;
    addrScsi   = 22'h000c00;
    set_reqs(4'b1111);

    // Reset held with every request active, then release.
    repeat (8) @(posedge clk8);
    step_post_slot();
    _reset = 1'b1;

    // All four requesting: first round in index order starting from DskInt.
    wait_slot();
    check("first_ack_dskint", 32'(acks()), 32'h1);
    wait_slot();
    check("rr_second_dskext", 32'(acks()), 32'h2);
    wait_slot();
    check("rr_third_snd", 32'(acks()), 32'h4);
    wait_slot();
    check("rr_fourth_scsi", 32'(acks()), 32'h8);

    // Single requester: external floppy, ROM side with its base.
    step_post_slot();
    set_reqs(4'b0010);
    addrDskExt = 22'h001234;
    for (int i = 0; i < 3; i++) begin
      wait_slot();
      check("single_ack", 32'(acks()), 32'h2);
      check("single_addr", 32'(extraAddr), 32'h121234);
      check("single_rom", 32'(extraRomRead), 32'h1);
    end

    // Urgent sound: everyone requesting; measure decisions from just after a sound grant.
    step_post_slot();
    set_reqs(4'b1111);
    for (int i = 0; i < 8; i++) begin
      wait_slot();
      if (ackSnd) break;
    end
    step_post_slot();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      wait_slot();
      n++;
      if (ackSnd) break;
    end
    check("snd_latency", 32'(n), 32'd3);

    // SCSI write then SCSI read.
    step_post_slot();
    set_reqs(4'b1000);
    scsiWrite = 1'b1;
    addrScsi  = 22'h000100;
    wait_slot();
    check("scsi_wr_we", 32'(extraRamWrite), 32'h1);
    check("scsi_wr_addr", 32'(extraAddr), 32'h200100);
    check("scsi_wr_reads", 32'({extraRomRead, extraRamRead}), 32'h0);
    step_post_slot();
    scsiWrite = 1'b0;
    wait_slot();
    check("scsi_rd_oe", 32'({extraRamRead, extraRamWrite}), 32'h2);

    // Random traffic: a request only changes once idle or just acknowledged.
    for (int it = 0; it < 150; it++) begin
      step_post_slot();
      if (!reqDskInt || m_last_g == 0) begin
        reqDskInt  = 1'($urandom_range(0, 1));
        addrDskInt = 22'($urandom);
      end
      if (!reqDskExt || m_last_g == 1) begin
        reqDskExt  = 1'($urandom_range(0, 1));
        addrDskExt = 22'($urandom);
      end
      if (!reqSnd || m_last_g == 2) begin
        reqSnd  = ($urandom_range(0, 3) != 0);
        addrSnd = 22'($urandom);
      end
      if (!reqScsi || m_last_g == 3) begin
        reqScsi   = 1'($urandom_range(0, 1));
        scsiWrite = 1'($urandom_range(0, 1));
        addrScsi  = 22'($urandom);
      end
    end

    // Reset in the middle of an active extra slot.
    step_post_slot();
    set_reqs(4'b1111);
    n = 0;
    for (int i = 0; i < 16 && n == 0; i++) begin
      @(posedge clk8);
      #2;
      if (busCycle == 2'b10) n = 1;
    end
    check("midslot_ack_live", 32'(|acks()), 32'h1);
    _reset = 1'b0;
    exp_q.delete();
    m_ptr    = 0;
    m_wait   = 0;
    m_last_g = -1;
    #1;
    check("midslot_ack_drop", 32'({acks(), extraRomRead, extraRamRead, extraRamWrite}), 32'h0);
    check("midslot_addr_drop", 32'(extraAddr), 32'h0);
    repeat (3) @(posedge clk8);
    step_post_slot();
    _reset = 1'b1;
    wait_slot();
    check("post_reset_dskint", 32'(acks()), 32'h1);
    for (int i = 0; i < 8; i++) wait_slot();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
